// File: rtl/delay_pipe_pkg.sv
// Shared helpers for delay-line variants: tap clamping and in-flight count update.
package delay_pipe_pkg;

   // Limit a requested tap to the physical stage count.
   function automatic int unsigned clamp_sel(input int unsigned sel, input int unsigned max_sel);
      return (sel > max_sel) ? max_sel : sel;
   endfunction

   // Entry entering minus entry leaving; simultaneous enter/leave cancels.
   function automatic int unsigned pending_next(input int unsigned cur, input logic add,
                                                input logic sub);
      return cur + 32'(add) - 32'(sub);
   endfunction

endpackage

// File: rtl/delay_pipe_stage.sv
// One {valid, data} stage of the delay line with reset > flush > en > hold priority.
module delay_pipe_stage #(
   parameter int unsigned DW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   input  logic          en,
   input  logic          valid_i,
   input  logic [DW-1:0] data_i,
   output logic          valid_o,
   output logic [DW-1:0] data_o
);

   logic          valid_q;
   logic [DW-1:0] data_q;

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (en) begin
         valid_q <= valid_i;
         data_q  <= data_i;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/delay_pipe.sv
// Multi-channel stallable delay line with valid tracking, flush and a runtime-selected tap.
module delay_pipe
   import delay_pipe_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned CHANNELS  = 1,
   parameter int unsigned MAX_DELAY = 8,
   parameter int unsigned SEL_W     = $clog2(MAX_DELAY + 1),
   parameter int unsigned CNT_W     = $clog2(MAX_DELAY + 1)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      en,
   input  logic                      flush,
   input  logic [SEL_W-1:0]          delay_sel,
   input  logic                      in_valid,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   output logic                      out_valid,
   output logic [CHANNELS*WIDTH-1:0] out_data,
   output logic [CNT_W-1:0]          pending,
   output logic                      idle
);

   localparam int unsigned DW = CHANNELS * WIDTH;

   // Tap 0 is the live input (bypass); tap i is the output of stage i-1.
   logic [MAX_DELAY:0] tap_valid;
   logic [DW-1:0]      tap_data [0:MAX_DELAY];
   logic [SEL_W-1:0]   tap;
   logic [CNT_W-1:0]   pending_q;
   logic [CNT_W-1:0]   pending_d;

   assign tap_valid[0] = in_valid & en;
   assign tap_data[0]  = in_data;

   for (genvar i = 0; i < int'(MAX_DELAY); i++) begin : g_stage
      delay_pipe_stage #(.DW(DW)) u_stage (
         .clk     (clk),
         .reset   (reset),
         .flush   (flush),
         .en      (en),
         .valid_i (tap_valid[i]),
         .data_i  (tap_data[i]),
         .valid_o (tap_valid[i+1]),
         .data_o  (tap_data[i+1])
      );
   end

   assign tap       = SEL_W'(clamp_sel(32'(delay_sel), MAX_DELAY));
   assign out_valid = tap_valid[tap];
   assign out_data  = tap_data[tap];

   assign pending_d = CNT_W'(pending_next(32'(pending_q), in_valid, tap_valid[MAX_DELAY]));

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         pending_q <= '0;
      end else if (en) begin
         pending_q <= pending_d;
      end
   end

   assign pending = pending_q;
   assign idle    = (pending_q == '0);

endmodule

// File: tb/tb_delay_pipe.sv
// Directed self-checking bench for delay_pipe (WIDTH=8, CHANNELS=2, MAX_DELAY=8).
module tb_delay_pipe;

   logic        clk = 1'b0;
   logic        reset, en, flush, in_valid;
   logic [3:0]  delay_sel;
   logic [15:0] in_data;
   logic        out_valid;
   logic [15:0] out_data;
   logic [3:0]  pending;
   logic        idle;

   int total = 0;
   int bad   = 0;
   int cnt;

   delay_pipe #(.WIDTH(8), .CHANNELS(2), .MAX_DELAY(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .flush     (flush),
      .delay_sel (delay_sel),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_data  (out_data),
      .pending   (pending),
      .idle      (idle)
   );

   always #5 clk = ~clk;

   // Channel 1 carries the complement of channel 0 so lane swaps are caught.
   function automatic logic [15:0] pat(input logic [7:0] x);
      return {~x, x};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_flush();
      flush = 1'b1; en = 1'b0; in_valid = 1'b0;
      tick();
      flush = 1'b0;
   endtask

   // Inject one valid word, then count en cycles until it shows at the tap.
   task automatic measure(input logic [7:0] val, input logic [3:0] sel, input string tag,
                          input int exp_lat);
      delay_sel = sel; en = 1'b1; in_valid = 1'b1; in_data = pat(val);
      tick();
      in_valid = 1'b0; in_data = 16'h0;
      cnt = 1;
      while (out_valid !== 1'b1 && cnt < 20) begin
         tick();
         cnt++;
      end
      chk({tag, "_lat"}, 32'(cnt), 32'(exp_lat));
      chk({tag, "_data"}, 32'(out_data), 32'(pat(val)));
   endtask

   logic bub [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
   int   bub_pend [6] = '{1, 1, 2, 3, 3, 3};

   initial begin
      reset = 1'b1; en = 1'b0; flush = 1'b0; in_valid = 1'b0;
      in_data = 16'h0; delay_sel = 4'd3;
      tick(); tick();
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data",  32'(out_data),  32'd0);
      chk("rst_pend",  32'(pending),   32'd0);
      chk("rst_idle",  32'(idle),      32'd1);
      reset = 1'b0;

      // Steady stream at tap 3.
      for (int k = 1; k <= 12; k++) begin
         en = 1'b1; in_valid = 1'b1; in_data = pat(8'(k));
         tick();
         chk("stream_valid", 32'(out_valid), (k >= 3) ? 32'd1 : 32'd0);
         chk("stream_data",  32'(out_data),  (k >= 3) ? 32'(pat(8'(k - 2))) : 32'd0);
         chk("stream_pend",  32'(pending),   (k >= 8) ? 32'd8 : 32'(k));
      end

      // Stall: everything frozen, new input ignored.
      en = 1'b0; in_valid = 1'b1; in_data = pat(8'h99);
      for (int s = 0; s < 5; s++) begin
         tick();
         chk("stall_data",  32'(out_data),  32'(pat(8'd10)));
         chk("stall_valid", 32'(out_valid), 32'd1);
         chk("stall_pend",  32'(pending),   32'd8);
      end
      for (int k = 13; k <= 15; k++) begin
         en = 1'b1; in_valid = 1'b1; in_data = pat(8'(k));
         tick();
         chk("resume_data", 32'(out_data), 32'(pat(8'(k - 2))));
         chk("resume_pend", 32'(pending),  32'd8);
      end

      // Flush with 5 entries in flight; the word presented with flush is dropped.
      do_flush();
      chk("preflush_pend", 32'(pending), 32'd0);
      for (int k = 1; k <= 5; k++) begin
         en = 1'b1; in_valid = 1'b1; in_data = pat(8'(8'h20 + k));
         tick();
      end
      chk("five_pend", 32'(pending), 32'd5);
      flush = 1'b1; en = 1'b1; in_valid = 1'b1; in_data = pat(8'h77);
      tick();
      flush = 1'b0;
      chk("flush_valid", 32'(out_valid), 32'd0);
      chk("flush_data",  32'(out_data),  32'd0);
      chk("flush_pend",  32'(pending),   32'd0);
      chk("flush_idle",  32'(idle),      32'd1);
      in_valid = 1'b0; in_data = 16'h0;
      for (int s = 0; s < 4; s++) begin
         tick();
         chk("postflush_valid", 32'(out_valid), 32'd0);
         chk("postflush_pend",  32'(pending),   32'd0);
      end

      // Bypass at tap 0.
      delay_sel = 4'd0; en = 1'b1; in_valid = 1'b1; in_data = pat(8'h5A);
      #1;
      chk("bypass_data",  32'(out_data),  32'(pat(8'h5A)));
      chk("bypass_valid", 32'(out_valid), 32'd1);
      en = 1'b0;
      #1;
      chk("bypass_stall_valid", 32'(out_valid), 32'd0);
      chk("bypass_stall_data",  32'(out_data),  32'(pat(8'h5A)));

      // Tap extremes: 8 and clamped 15 give the same latency.
      do_flush();
      measure(8'h31, 4'd8, "tap8", 8);
      do_flush();
      measure(8'h32, 4'd15, "tap15", 8);

      // Bubbles at tap 2.
      do_flush();
      delay_sel = 4'd2; en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         in_valid = (i < 5) ? bub[i] : 1'b0;
         in_data  = pat(8'(8'h40 + i));
         tick();
         chk("bubble_pend", 32'(pending), 32'(bub_pend[i]));
         if (i >= 1) begin
            chk("bubble_valid", 32'(out_valid), 32'(bub[i-1]));
         end
      end

      // Reset mid-stream behaves like flush; then fresh latency at tap 3.
      do_flush();
      delay_sel = 4'd3;
      for (int k = 1; k <= 5; k++) begin
         en = 1'b1; in_valid = 1'b1; in_data = pat(8'(8'h50 + k));
         tick();
      end
      chk("prereset_pend", 32'(pending), 32'd5);
      reset = 1'b1; en = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = pat(8'h99);
      tick();
      reset = 1'b0;
      chk("midrst_valid", 32'(out_valid), 32'd0);
      chk("midrst_data",  32'(out_data),  32'd0);
      chk("midrst_pend",  32'(pending),   32'd0);
      chk("midrst_idle",  32'(idle),      32'd1);
      measure(8'h61, 4'd3, "after_rst", 3);
      chk("after_rst_pend", 32'(pending), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
